fetch_inst_queue: RTL and testbench

//  Receiving end of the fetch interface: a small FIFO between the instruction-fetch stage and decode.

---
 rtl/fetch_pkg.sv | 33 +++
 rtl/fetch_inst_queue_mem.sv | 37 +++
 rtl/fetch_inst_queue.sv | 129 ++++++++++++
 tb/tb_fetch_inst_queue.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: definitions shared by the fetch-to-decode instruction queue.
//  DATA_W        width of an instruction word and of a PC
//  INST_NOP      word presented to decode when no entry is valid
//  OPC_W/OPC_HI/OPC_LO  position of the opcode field inside an instruction
//  fetch_entry_t one queue entry: {pc, instr}
package fetch_pkg;

  localparam int DATA_W = 32;
  localparam logic [31:0] INST_NOP = 32'h0000_0000;
  localparam int OPC_W  = 6;
  localparam int OPC_HI = 31;
  localparam int OPC_LO = 26;

  typedef struct packed {
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] instr;
  } fetch_entry_t;

  // Opcode field of an instruction word (000000 marks a word past program end).
  function automatic logic [OPC_W-1:0] opcode_of(input logic [DATA_W-1:0] instr);
    return instr[OPC_HI:OPC_LO];
  endfunction

  // Pack a fetched {pc, instruction} pair into one entry.
  function automatic fetch_entry_t make_entry(input logic [DATA_W-1:0] pc,
                                              input logic [DATA_W-1:0] instr);
    fetch_entry_t e;
    e.pc    = pc;
    e.instr = instr;
    return e;
  endfunction

endpackage

// File: rtl/fetch_inst_queue_mem.sv
// fetch_inst_queue_mem: DEPTH x WIDTH register file holding queue entries.
//  One synchronous write port, one asynchronous read port, no reset: the
//  queue's validity is tracked purely by pointers and count in the parent.
// Ports:
//  clk    in   clock
//  we     in   write enable
//  waddr  in   write address
//  wdata  in   write data
//  raddr  in   read address
//  rdata  out  read data (combinational from raddr)
module fetch_inst_queue_mem
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2,
  parameter int WIDTH = 2 * fetch_pkg::DATA_W
) (
  input  logic             clk,
  input  logic             we,
  input  logic [PTR_W-1:0] waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [PTR_W-1:0] raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write port: storage is intentionally not reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fetch_inst_queue.sv
// fetch_inst_queue: small FIFO between instruction fetch and decode.
//  Captures the {PC, instruction} pair fetch presents every cycle, stalls
//  fetch while full, presents the oldest entry to decode first-word-fall-
//  through with a valid/ready handshake, and empties on a taken branch.
// Ports:
//  clk, rst         clock; synchronous active-high reset
//  if_instruction   instruction from fetch for if_pc
//  if_pc            PC of if_instruction
//  fetch_stall      holds the fetch PC while the queue is full
//  branch_taken     flush: drops queue contents and this cycle's fetch word
//  id_ready         decode can accept the head this cycle
//  id_valid         head entry valid
//  id_instruction   head instruction, NOP when !id_valid
//  id_pc            head PC, 0 when !id_valid
//  occupancy        entry count 0..DEPTH
//  stall_cycles     saturating count of cycles with fetch_stall=1
module fetch_inst_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int PTR_W  = 2,
  parameter int DATA_W = fetch_pkg::DATA_W,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] if_instruction,
  input  logic [DATA_W-1:0] if_pc,
  output logic              fetch_stall,
  input  logic              branch_taken,
  input  logic              id_ready,
  output logic              id_valid,
  output logic [DATA_W-1:0] id_instruction,
  output logic [DATA_W-1:0] id_pc,
  output logic [PTR_W:0]    occupancy,
  output logic [CNT_W-1:0]  stall_cycles
);

  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(DEPTH);

  logic [PTR_W-1:0]    rd_ptr;
  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W:0]      count;
  logic                full;
  logic                enq;
  logic                deq;
  logic [PTR_W:0]      count_next;
  logic [2*DATA_W-1:0] wr_entry;
  logic [2*DATA_W-1:0] rd_entry;

  // Full blocks enq even when a deq happens in the same cycle, so fetch only
  // resumes the cycle after the count has actually dropped.
  assign full        = (count == FULL_COUNT);
  assign fetch_stall = full;
  assign id_valid    = (count != {(PTR_W+1){1'b0}});
  assign enq         = !rst && !branch_taken && !full;
  assign deq         = !rst && !branch_taken && id_valid && id_ready;
  assign occupancy   = count;

  assign wr_entry = {if_pc, if_instruction};

  fetch_inst_queue_mem #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W),
    .WIDTH (2 * DATA_W)
  ) u_mem (
    .clk   (clk),
    .we    (enq),
    .waddr (wr_ptr),
    .wdata (wr_entry),
    .raddr (rd_ptr),
    .rdata (rd_entry)
  );

  // Head outputs: first-word-fall-through, forced to NOP / 0 when empty.
  always_comb begin
    id_instruction = DATA_W'(INST_NOP);
    id_pc          = {DATA_W{1'b0}};
    if (id_valid) begin
      id_pc          = rd_entry[2*DATA_W-1:DATA_W];
      id_instruction = rd_entry[DATA_W-1:0];
    end else begin
      id_pc          = {DATA_W{1'b0}};
      id_instruction = DATA_W'(INST_NOP);
    end
  end

  // Next count: simultaneous enq and deq cancel out.
  always_comb begin
    count_next = count;
    case ({enq, deq})
      2'b10:   count_next = count + (PTR_W+1)'(1);
      2'b01:   count_next = count - (PTR_W+1)'(1);
      default: count_next = count;
    endcase
  end

  // Pointer and count state; reset overrides flush, flush overrides enq/deq.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= {PTR_W{1'b0}};
      wr_ptr <= {PTR_W{1'b0}};
      count  <= {(PTR_W+1){1'b0}};
    end else if (branch_taken) begin
      rd_ptr <= {PTR_W{1'b0}};
      wr_ptr <= {PTR_W{1'b0}};
      count  <= {(PTR_W+1){1'b0}};
    end else begin
      // Power-of-two depth: pointers wrap naturally.
      if (enq) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (deq) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count <= count_next;
    end
  end

  // Saturating stall-cycle counter; survives flush, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= {CNT_W{1'b0}};
    end else if (fetch_stall && (stall_cycles != {CNT_W{1'b1}})) begin
      stall_cycles <= stall_cycles + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_fetch_inst_queue.sv
// tb_fetch_inst_queue: directed scenarios plus randomized traffic, checked
// against a queue-based reference model of the fetch instruction queue.
module tb_fetch_inst_queue;

  logic        clk;
  logic        rst;
  logic [31:0] if_instruction;
  logic [31:0] if_pc;
  logic        fetch_stall;
  logic        branch_taken;
  logic        id_ready;
  logic        id_valid;
  logic [31:0] id_instruction;
  logic [31:0] id_pc;
  logic [2:0]  occupancy;
  logic [15:0] stall_cycles;

  int tests = 0;
  int fails = 0;

  // Reference model: entries as {pc, instr}, oldest first.
  logic [63:0] mq[$];
  int          m_stall;
  logic [31:0] elog[$];   // pcs accepted by the queue, in order
  logic [31:0] obs[$];    // pcs the DUT handed to decode, in order

  fetch_inst_queue dut (
    .clk            (clk),
    .rst            (rst),
    .if_instruction (if_instruction),
    .if_pc          (if_pc),
    .fetch_stall    (fetch_stall),
    .branch_taken   (branch_taken),
    .id_ready       (id_ready),
    .id_valid       (id_valid),
    .id_instruction (id_instruction),
    .id_pc          (id_pc),
    .occupancy      (occupancy),
    .stall_cycles   (stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] exp_pc();
    return (mq.size() != 0) ? mq[0][63:32] : 32'd0;
  endfunction

  function automatic logic [31:0] exp_ins();
    return (mq.size() != 0) ? mq[0][31:0] : 32'd0;
  endfunction

  function automatic logic [31:0] rnd_ins();
    logic [31:0] w;
    w = $urandom;
    if ($urandom_range(0, 3) == 0) w[31:26] = 6'b000000;
    return w;
  endfunction

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic model_step();
    bit was_full;
    bit do_deq;
    was_full = (mq.size() == 4);
    if (rst) begin
      mq.delete();
      m_stall = 0;
    end else begin
      if (was_full && m_stall < 65535) m_stall++;
      if (branch_taken) begin
        mq.delete();
      end else begin
        do_deq = (mq.size() != 0) && id_ready;
        if (do_deq) void'(mq.pop_front());
        if (!was_full) begin
          mq.push_back({if_pc, if_instruction});
          elog.push_back(if_pc);
        end
      end
    end
  endtask

  // One cycle: drive at negedge, log handshakes, clock, update model, settle.
  task automatic cycle(input logic r, input logic br, input logic rdy,
                       input logic [31:0] pc, input logic [31:0] ins);
    @(negedge clk);
    rst = r; branch_taken = br; id_ready = rdy; if_pc = pc; if_instruction = ins;
    #1;
    if (!r && !br && id_valid && rdy) obs.push_back(id_pc);
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    cycle(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
    cycle(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
    tests++; if (id_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %0b expected 0", id_valid); end
    tests++; if (id_pc !== 32'd0) begin fails++; $display("FAIL reset_pc: got %h expected 0", id_pc); end
    tests++; if (id_instruction !== 32'd0) begin fails++; $display("FAIL reset_instr: got %h expected 0", id_instruction); end
    tests++; if (occupancy !== 3'd0) begin fails++; $display("FAIL reset_occ: got %0d expected 0", occupancy); end
    tests++; if (fetch_stall !== 1'b0) begin fails++; $display("FAIL reset_stall: got %0b expected 0", fetch_stall); end
    tests++; if (stall_cycles !== 16'd0) begin fails++; $display("FAIL reset_cnt: got %0d expected 0", stall_cycles); end
  endtask

  task automatic test_stream();
    logic [31:0] ins;
    cycle(1'b1, 1'b0, 1'b1, 32'd0, 32'd0);
    for (int i = 1; i <= 3; i++) begin
      ins = rnd_ins();
      cycle(1'b0, 1'b0, 1'b1, 32'(4 * i), ins);
      tests++; if (id_valid !== 1'b1) begin fails++; $display("FAIL stream_valid%0d: got %0b expected 1", i, id_valid); end
      tests++; if (id_pc !== 32'(4 * i)) begin fails++; $display("FAIL stream_pc%0d: got %0d expected %0d", i, id_pc, 4 * i); end
      tests++; if (id_instruction !== ins) begin fails++; $display("FAIL stream_ins%0d: got %h expected %h", i, id_instruction, ins); end
      tests++; if (occupancy > 3'd1) begin fails++; $display("FAIL stream_occ%0d: got %0d expected <=1", i, occupancy); end
      tests++; if (fetch_stall !== 1'b0) begin fails++; $display("FAIL stream_stall%0d: got %0b expected 0", i, fetch_stall); end
    end
  endtask

  task automatic test_full();
    cycle(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
    for (int i = 1; i <= 4; i++) cycle(1'b0, 1'b0, 1'b0, 32'(4 * i), rnd_ins());
    tests++; if (occupancy !== 3'd4) begin fails++; $display("FAIL full_occ: got %0d expected 4", occupancy); end
    tests++; if (fetch_stall !== 1'b1) begin fails++; $display("FAIL full_stall: got %0b expected 1", fetch_stall); end
    for (int i = 1; i <= 2; i++) begin
      cycle(1'b0, 1'b0, 1'b0, 32'd20, 32'hDEAD_0020);
      tests++; if (stall_cycles !== 16'(i)) begin fails++; $display("FAIL full_cnt%0d: got %0d expected %0d", i, stall_cycles, i); end
      tests++; if (occupancy !== 3'd4 || id_pc !== 32'd4) begin fails++; $display("FAIL full_hold%0d: got occ %0d pc %0d expected occ 4 pc 4", i, occupancy, id_pc); end
    end
    // One dequeue while full: no enqueue that edge.
    cycle(1'b0, 1'b0, 1'b1, 32'd20, 32'hDEAD_0020);
    tests++; if (occupancy !== 3'd3) begin fails++; $display("FAIL deqfull_occ: got %0d expected 3", occupancy); end
    tests++; if (id_pc !== 32'd8) begin fails++; $display("FAIL deqfull_pc: got %0d expected 8", id_pc); end
    tests++; if (fetch_stall !== 1'b0) begin fails++; $display("FAIL deqfull_stall: got %0b expected 0", fetch_stall); end
    tests++; if (stall_cycles !== 16'd3) begin fails++; $display("FAIL deqfull_cnt: got %0d expected 3", stall_cycles); end
    cycle(1'b0, 1'b0, 1'b0, 32'd20, 32'hDEAD_0020);
    tests++; if (occupancy !== 3'd4) begin fails++; $display("FAIL resume_occ: got %0d expected 4", occupancy); end
    tests++; if (stall_cycles !== 16'd3) begin fails++; $display("FAIL resume_cnt: got %0d expected 3", stall_cycles); end
    // Drain and confirm pc 20 landed behind 8,12,16.
    for (int i = 0; i < 6; i++) begin
      cycle(1'b0, 1'b0, 1'b1, 32'(100 + 4 * i), rnd_ins());
      tests++; if (id_pc !== exp_pc() || occupancy !== 3'(mq.size())) begin
        fails++; $display("FAIL drain%0d: got pc %0d occ %0d expected pc %0d occ %0d", i, id_pc, occupancy, exp_pc(), mq.size());
      end
    end
  endtask

  task automatic test_flush();
    cycle(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
    cycle(1'b0, 1'b0, 1'b0, 32'd4, rnd_ins());
    cycle(1'b0, 1'b0, 1'b0, 32'd8, rnd_ins());
    tests++; if (occupancy !== 3'd2) begin fails++; $display("FAIL preflush_occ: got %0d expected 2", occupancy); end
    cycle(1'b0, 1'b1, 1'b1, 32'd12, rnd_ins());
    tests++; if (occupancy !== 3'd0) begin fails++; $display("FAIL flush_occ: got %0d expected 0", occupancy); end
    tests++; if (id_valid !== 1'b0) begin fails++; $display("FAIL flush_valid: got %0b expected 0", id_valid); end
    tests++; if (id_instruction !== 32'd0) begin fails++; $display("FAIL flush_ins: got %h expected 0", id_instruction); end
    cycle(1'b0, 1'b0, 1'b0, 32'd40, 32'h1234_5678);
    tests++; if (id_pc !== 32'd40 || id_instruction !== 32'h1234_5678) begin
      fails++; $display("FAIL flush_target: got pc %0d ins %h expected pc 40 ins 12345678", id_pc, id_instruction);
    end
  endtask

  task automatic test_wrap();
    cycle(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
    elog.delete(); obs.delete();
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, 1'((i + 1) % 2), 32'(200 + 4 * i), rnd_ins());
    for (int i = 0; i < obs.size(); i++) begin
      tests++; if (i >= elog.size() || obs[i] !== elog[i]) begin
        fails++; $display("FAIL wrap_order%0d: got %0d expected %0d", i, obs[i], (i < elog.size()) ? elog[i] : 32'hFFFF_FFFF);
      end
    end
    tests++; if (obs.size() + int'(occupancy) != elog.size()) begin
      fails++; $display("FAIL wrap_count: got %0d expected %0d", obs.size() + int'(occupancy), elog.size());
    end
  endtask

  task automatic test_random();
    logic r, br, rdy;
    for (int i = 0; i < 400; i++) begin
      r   = ($urandom_range(0, 49) == 0);
      br  = ($urandom_range(0, 11) == 0);
      rdy = ($urandom_range(0, 2) != 0);
      cycle(r, br, rdy, $urandom, rnd_ins());
      tests++; if (id_valid !== (mq.size() != 0) || id_pc !== exp_pc() || id_instruction !== exp_ins()) begin
        fails++; $display("FAIL rand_head%0d: got v%0b pc %h ins %h expected v%0b pc %h ins %h",
                          i, id_valid, id_pc, id_instruction, mq.size() != 0, exp_pc(), exp_ins());
      end
      tests++; if (occupancy !== 3'(mq.size()) || fetch_stall !== (mq.size() == 4) || stall_cycles !== 16'(m_stall)) begin
        fails++; $display("FAIL rand_state%0d: got occ %0d stall %0b cnt %0d expected occ %0d stall %0b cnt %0d",
                          i, occupancy, fetch_stall, stall_cycles, mq.size(), mq.size() == 4, m_stall);
      end
    end
  endtask

  task automatic test_reset_mid();
    cycle(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 1'b0, 32'(4 * i + 4), rnd_ins());
    cycle(1'b0, 1'b0, 1'b0, 32'd20, rnd_ins());   // full: bump stall_cycles
    cycle(1'b0, 1'b0, 1'b1, 32'd20, rnd_ins());   // leave 3 entries
    tests++; if (occupancy !== 3'd3 || stall_cycles === 16'd0) begin
      fails++; $display("FAIL premid: got occ %0d cnt %0d expected occ 3 cnt >0", occupancy, stall_cycles);
    end
    cycle(1'b1, 1'b1, 1'b1, 32'd24, rnd_ins());
    tests++; if (occupancy !== 3'd0 || id_valid !== 1'b0 || fetch_stall !== 1'b0) begin
      fails++; $display("FAIL mid_state: got occ %0d v %0b stall %0b expected 0 0 0", occupancy, id_valid, fetch_stall);
    end
    tests++; if (id_pc !== 32'd0 || id_instruction !== 32'd0) begin
      fails++; $display("FAIL mid_head: got pc %h ins %h expected 0 0", id_pc, id_instruction);
    end
    tests++; if (stall_cycles !== 16'd0) begin fails++; $display("FAIL mid_cnt: got %0d expected 0", stall_cycles); end
  endtask

  initial begin
    rst = 1'b1; branch_taken = 1'b0; id_ready = 1'b0; if_pc = 32'd0; if_instruction = 32'd0;
    m_stall = 0;
    test_reset();
    test_stream();
    test_full();
    test_flush();
    test_wrap();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
